// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR polynomial constants and single-step helper
package lfsr_pkg;

  localparam logic [7:0]  POLY8  = 8'hB8;
  localparam logic [15:0] POLY16 = 16'hB400;
  localparam logic [31:0] POLY32 = 32'hA300_0000;

  typedef struct packed {
    logic [31:0] nextState;
    logic        outBit;
  } lfsr_step_t;

  function automatic logic [31:0] allOnes(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  // States wider than the configured width are carried zero-extended in 32 bits.
  function automatic lfsr_step_t lfsr_step(input logic [31:0] state,
                                           input logic [31:0] poly,
                                           input int          width);
    lfsr_step_t r;
    r.outBit    = state[5'(width - 1)];
    r.nextState = {state[30:0], ^(state & poly)} & allOnes(width);
    return r;
  endfunction

endpackage

// File: rtl/lfsr_scrambler_if.sv
// rtl/lfsr_scrambler_if.sv - source/destination valid-ready beat interface
interface lfsr_scrambler_if
  import lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                  iSrcValid;
  logic [DATA_WIDTH-1:0] iSrcData;
  logic                  oSrcReady;
  logic                  oDstValid;
  logic [DATA_WIDTH-1:0] oDstData;
  logic                  iDstReady;

  modport master (
    output iSrcValid, iSrcData, iDstReady,
    input  oSrcReady, oDstValid, oDstData
  );

  modport slave (
    input  iSrcValid, iSrcData, iDstReady,
    output oSrcReady, oDstValid, oDstData
  );

endinterface

// File: rtl/lfsr_unroll.sv
// rtl/lfsr_unroll.sv - combinational DATA_WIDTH-step Fibonacci LFSR unroll
module lfsr_unroll
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] POLY       = LFSR_WIDTH'(POLY16)
) (
  input  logic [LFSR_WIDTH-1:0] iState,
  output logic [LFSR_WIDTH-1:0] oNextState,
  output logic [DATA_WIDTH-1:0] oKeystream
);

  logic [31:0] walk;
  lfsr_step_t  stepR;

  always_comb begin
    walk       = 32'(iState);
    stepR      = '0;
    oKeystream = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      stepR         = lfsr_step(walk, 32'(POLY), LFSR_WIDTH);
      oKeystream[i] = stepR.outBit;
      walk          = stepR.nextState;
    end
    oNextState = walk[LFSR_WIDTH-1:0];
  end

endmodule

// File: rtl/lfsr_scrambler.sv
// rtl/lfsr_scrambler.sv - streaming LFSR scrambler/descrambler, optional page auto-reseed via LFSR_SCRAMBLER_AUTORESEED_EN
module lfsr_scrambler
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] POLY       = LFSR_WIDTH'(POLY16)
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
  ,
  parameter int                    PAGE_BEATS = 512
`endif
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic [LFSR_WIDTH-1:0] iSeed,
  input  logic                  iSeedLoad,
  lfsr_scrambler_if.slave       bus,
  output logic [LFSR_WIDTH-1:0] oState
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
  ,
  output logic                  oPageDone
`endif
);

  localparam logic [LFSR_WIDTH-1:0] ONES = LFSR_WIDTH'(allOnes(LFSR_WIDTH));

  logic [LFSR_WIDTH-1:0] stateQ;
  logic [LFSR_WIDTH-1:0] stateD;
  logic [LFSR_WIDTH-1:0] seedEff;
  logic [LFSR_WIDTH-1:0] baseState;
  logic [LFSR_WIDTH-1:0] unrolledState;
  logic [DATA_WIDTH-1:0] keystream;
  logic                  accept;
  logic                  reseedNow;
  logic [LFSR_WIDTH-1:0] reseedValue;

  // A zero seed would lock the LFSR, so it is replaced by all-ones.
  assign seedEff   = (iSeed == '0) ? ONES : iSeed;
  assign baseState = iSeedLoad ? seedEff : stateQ;

  assign bus.oSrcReady = !bus.oDstValid || bus.iDstReady;
  assign accept        = bus.iSrcValid && bus.oSrcReady;
  assign oState        = stateQ;

  lfsr_unroll #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .POLY       (POLY)
  ) uUnroll (
    .iState     (baseState),
    .oNextState (unrolledState),
    .oKeystream (keystream)
  );

`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
  localparam int CNT_W = (PAGE_BEATS > 1) ? $clog2(PAGE_BEATS) : 1;

  logic [CNT_W-1:0]      beatCnt;
  logic [LFSR_WIDTH-1:0] lastSeed;

  // A seed load in the wrap cycle starts a fresh page instead of replaying the old seed.
  assign reseedNow   = accept && !iSeedLoad && (beatCnt == CNT_W'(PAGE_BEATS - 1));
  assign reseedValue = lastSeed;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      beatCnt   <= '0;
      lastSeed  <= ONES;
      oPageDone <= 1'b0;
    end else begin
      if (iSeedLoad) begin
        beatCnt  <= '0;
        lastSeed <= seedEff;
      end else if (accept) begin
        beatCnt <= reseedNow ? '0 : beatCnt + 1'b1;
      end
      if (accept) begin
        oPageDone <= reseedNow;
      end else if (bus.iDstReady) begin
        oPageDone <= 1'b0;
      end
    end
  end
`else
  assign reseedNow   = 1'b0;
  assign reseedValue = ONES;
`endif

  always_comb begin
    stateD = stateQ;
    if (accept) begin
      stateD = reseedNow ? reseedValue : unrolledState;
    end else if (iSeedLoad) begin
      stateD = seedEff;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      stateQ        <= ONES;
      bus.oDstValid <= 1'b0;
      bus.oDstData  <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        bus.oDstValid <= 1'b1;
        bus.oDstData  <= bus.iSrcData ^ keystream;
      end else if (bus.iDstReady) begin
        bus.oDstValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_scrambler.sv
// tb/tb_lfsr_scrambler.sv - randomized self-checking bench with a bit-sequence LFSR model
module tb_lfsr_scrambler;

  localparam logic [15:0] POLY = 16'hB400;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iSeed;
  logic        iSeedLoad;
  logic [15:0] oState;
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
  logic        oPageDone;
`endif

  lfsr_scrambler_if #(.DATA_WIDTH(32)) bus ();

  lfsr_scrambler #(
    .LFSR_WIDTH (16),
    .DATA_WIDTH (32),
    .POLY       (POLY)
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
    ,
    .PAGE_BEATS (4)
`endif
  ) dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iSeed     (iSeed),
    .iSeedLoad (iSeedLoad),
    .bus       (bus),
    .oState    (oState)
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
    ,
    .oPageDone (oPageDone)
`endif
  );

  always #5 iClock = ~iClock;

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  logic [15:0] mState;
  logic        mValid;
  logic [31:0] mData;
  logic [15:0] mLast;
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
  int          mCnt;
  logic        mPage;
  bit          pdQ[$];
`endif

  logic [31:0] outQ[$];
  logic [31:0] origQ[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Keystream as a plain bit sequence: seed bits MSB first, then s[n+16] = XOR of tapped earlier bits.
  function automatic void modelBeat(input logic [15:0] s, output logic [31:0] ks, output logic [15:0] nxt);
    bit seq[$];
    int n;
    bit b;
    for (int k = 15; k >= 0; k--) seq.push_back(s[k]);
    while (seq.size() < 48) begin
      n = seq.size() - 16;
      b = 1'b0;
      for (int k = 0; k < 16; k++) if (POLY[k]) b ^= seq[n + 15 - k];
      seq.push_back(b);
    end
    for (int i = 0; i < 32; i++) ks[i] = seq[i];
    for (int k = 0; k < 16; k++) nxt[15 - k] = seq[32 + k];
  endfunction

  always @(negedge iClock) begin
    if (checkOn) begin
      chk("dst_valid", {63'd0, bus.oDstValid}, {63'd0, mValid});
      if (mValid) chk("dst_data", {32'd0, bus.oDstData}, {32'd0, mData});
      chk("state", {48'd0, oState}, {48'd0, mState});
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
      if (mValid) chk("page_done", {63'd0, oPageDone}, {63'd0, mPage});
`endif
    end
  end

  task automatic step(input bit srcV, input logic [31:0] d, input bit dstR,
                      input bit ld, input logic [15:0] seed, input bit rst);
    logic [31:0] ks;
    logic [15:0] nxt, seedEff, base;
    bit acc, wrap;
    @(negedge iClock);
    bus.iSrcValid = srcV;
    bus.iSrcData  = d;
    bus.iDstReady = dstR;
    iSeedLoad     = ld;
    iSeed         = seed;
    iReset        = rst;
    #1;
    if (rst) begin
      mState = 16'hFFFF; mValid = 1'b0; mData = '0; mLast = 16'hFFFF;
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
      mCnt = 0; mPage = 1'b0;
`endif
    end else begin
      chk("src_ready", {63'd0, bus.oSrcReady}, {63'd0, (!mValid || dstR)});
      if (bus.oDstValid && dstR) begin
        outQ.push_back(bus.oDstData);
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
        pdQ.push_back(oPageDone);
`endif
      end
      seedEff = (seed == 16'h0) ? 16'hFFFF : seed;
      base    = ld ? seedEff : mState;
      acc     = srcV && (!mValid || dstR);
      wrap    = 1'b0;
`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
      wrap = acc && !ld && (mCnt == 3);
      if (ld) begin
        mCnt = 0; mLast = seedEff;
      end else if (acc) begin
        mCnt = wrap ? 0 : mCnt + 1;
      end
      if (acc) mPage = wrap;
      else if (dstR) mPage = 1'b0;
`endif
      if (acc) begin
        modelBeat(base, ks, nxt);
        mData  = d ^ ks;
        mValid = 1'b1;
        mState = wrap ? mLast : nxt;
      end else begin
        if (dstR) mValid = 1'b0;
        if (ld) mState = seedEff;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] ks, d, firstOut, holdD;
    logic [15:0] nxt, holdS;
    logic [31:0] scr[$];

    bus.iSrcValid = 1'b0; bus.iSrcData = '0; bus.iDstReady = 1'b0;
    iSeedLoad = 1'b0; iSeed = '0; iReset = 1'b1;

    modelBeat(16'hFFFF, ks, nxt);
    chk("model_pin_ks", {32'd0, ks & 32'h0FFF_FFFF}, {32'd0, 32'h0800_FFFF});

    step(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    checkOn = 1'b1;
    idle();
    chk("reset_state", {48'd0, oState}, 64'hFFFF);
    chk("reset_valid", {63'd0, bus.oDstValid}, 64'd0);
    chk("reset_data", {32'd0, bus.oDstData}, 64'd0);

    // First beat after reset with zero data exposes the keystream directly.
    step(1'b1, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle();
    chk("first_valid", {63'd0, bus.oDstValid}, 64'd1);
    chk("first_lo16", {48'd0, bus.oDstData[15:0]}, 64'hFFFF);
    firstOut = bus.oDstData;

    step(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 16'h0000, 1'b0);
    idle();
    chk("seed0_state", {48'd0, oState}, 64'hFFFF);
    step(1'b1, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle();
    chk("seed0_out", {32'd0, bus.oDstData}, {32'd0, firstOut});

    // Round trip through the same seed must restore the data.
    step(1'b0, 32'h0, 1'b1, 1'b1, 16'hACE1, 1'b0);
    outQ.delete(); origQ.delete();
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      origQ.push_back(d);
      step(1'b1, d, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    idle();
    scr = outQ;
    outQ.delete();
    step(1'b0, 32'h0, 1'b1, 1'b1, 16'hACE1, 1'b0);
    foreach (scr[i]) step(1'b1, scr[i], 1'b1, 1'b0, 16'h0, 1'b0);
    idle();
    chk("rt_count", 64'(outQ.size()), 64'd64);
    for (int i = 0; i < 64 && i < outQ.size(); i++)
      chk($sformatf("rt_beat%0d", i), {32'd0, outQ[i]}, {32'd0, origQ[i]});

    // Backpressure: a pending beat must freeze output and LFSR.
    step(1'b1, $urandom, 1'b1, 1'b0, 16'h0, 1'b0);
    d = $urandom;
    step(1'b1, d, 1'b0, 1'b0, 16'h0, 1'b0);
    holdD = bus.oDstData;
    holdS = oState;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("bp_ready", {63'd0, bus.oSrcReady}, 64'd0);
      chk("bp_data", {32'd0, bus.oDstData}, {32'd0, holdD});
      chk("bp_state", {48'd0, oState}, {48'd0, holdS});
    end
    step(1'b1, d, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0, 16'h0, 1'b0);
    idle();

    // Seed load coinciding with an accept keys that beat from the new seed.
    d = $urandom;
    step(1'b1, d, 1'b1, 1'b1, 16'h1234, 1'b0);
    idle();
    modelBeat(16'h1234, ks, nxt);
    chk("sl_beat", {32'd0, bus.oDstData}, {32'd0, d ^ ks});
    chk("sl_state", {48'd0, oState}, {48'd0, nxt});

    step(1'b1, $urandom, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, 16'h0, 1'b1);
    idle();
    chk("rst_valid", {63'd0, bus.oDstValid}, 64'd0);
    chk("rst_state", {48'd0, oState}, 64'hFFFF);

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0,
           (($urandom % 4) == 0) ? 16'h0 : 16'($urandom), 1'b0);
    end
    idle();

`ifdef LFSR_SCRAMBLER_AUTORESEED_EN
    step(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 16'hACE1, 1'b0);
    outQ.delete(); origQ.delete(); pdQ.delete();
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      origQ.push_back(d);
      step(1'b1, d, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    idle();
    chk("page_count", 64'(outQ.size()), 64'd8);
    for (int i = 4; i < 8 && i < outQ.size(); i++)
      chk($sformatf("page_ks%0d", i), {32'd0, outQ[i] ^ origQ[i]}, {32'd0, outQ[i-4] ^ origQ[i-4]});
    for (int i = 0; i < 8 && i < pdQ.size(); i++)
      chk($sformatf("page_done%0d", i), {63'd0, pdQ[i]}, {63'd0, (i == 3 || i == 7)});
`endif

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
